// File: rtl/ps2_tx_apb.sv
// APB-attached PS/2 device-side transmitter: FIFO-fed scan-code serialiser.
// Optional: define PS2_TX_SLVERR_EN to flag DATA writes rejected on a full FIFO via in_pslverr.
module ps2_tx_apb #(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic        ps2_clk,
  output logic        ps2_data
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CNT_FW = FIFO_AW + 1;
  localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);

  typedef enum logic [1:0] {IDLE, SETUP, LOW, GAP} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [10:0]          shift_q, shift_d;
  logic                 ps2_clk_q, ps2_clk_d;
  logic                 ps2_data_q, ps2_data_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]    count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];

  logic apb_fire, wr_en, rd_en, sel_data, sel_stat;
  logic flush, ovf_clr, push_req, push, reject, pop;
  logic full, empty, busy;
  logic [7:0] pop_byte;

  // APB decode: zero wait states, access completes on pready.
  assign apb_fire = in_psel & in_penable;
  assign wr_en    = apb_fire & in_pwrite;
  assign rd_en    = apb_fire & ~in_pwrite;
  assign sel_data = (in_paddr[3:2] == 2'b00);
  assign sel_stat = (in_paddr[3:2] == 2'b01);

  assign full     = (count_q == CNT_FW'(DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != IDLE);

  assign flush    = wr_en & sel_stat & in_pwdata[0];
  assign ovf_clr  = wr_en & sel_stat & in_pwdata[3];
  assign push_req = wr_en & sel_data;
  // Full is judged on the pre-pop count, so a same-cycle pop never rescues a push.
  assign push     = push_req & ~full & ~flush;
  assign reject   = push_req & full;
  assign pop      = (state_q == IDLE) & ~empty;
  assign pop_byte = mem_q[rd_ptr_q];

  assign in_pready = apb_fire;

  always_comb begin
    in_prdata = 32'h0;
    if (rd_en && sel_stat) begin
      in_prdata = 32'({4'(count_q), ovf_q, busy, full, empty});
    end
  end

`ifdef PS2_TX_SLVERR_EN
  assign in_pslverr = reject;
`else
  assign in_pslverr = 1'b0;
`endif

  logic unused_c;
  assign unused_c = ^{in_pprot, in_pstrb, in_paddr[31:4], in_paddr[1:0], in_pwdata[31:8]};

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (reject) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_pwdata[7:0];
        wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_FW'(1);
        2'b01:   count_d = count_q - CNT_FW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Frame FSM: data only ever moves on the edge where ps2_clk rises (SETUP entry).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;

    case (state_q)
      IDLE: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (pop) begin
          shift_d    = {1'b1, ~^pop_byte, pop_byte, 1'b0};
          ps2_data_d = 1'b0;
          bit_idx_d  = 4'd0;
          cnt_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_W'(CLK_DIV - 1)) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b0;
          state_d   = LOW;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == DIV_W'(CLK_DIV - 1)) begin
          cnt_d     = '0;
          ps2_clk_d = 1'b1;
          if (bit_idx_q == 4'd10) begin
            ps2_data_d = 1'b1;
            state_d    = GAP;
          end else begin
            bit_idx_d  = bit_idx_q + 4'd1;
            ps2_data_d = shift_q[1];
            shift_d    = {1'b1, shift_q[10:1]};
            state_d    = SETUP;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      GAP: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (cnt_q == DIV_W'(2 * CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 4'd0;
      shift_q    <= 11'h7FF;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_tx_apb.sv
// Directed self-checking bench for ps2_tx_apb with a PS/2 receiver model on the lines.
module tb_ps2_tx_apb;

  localparam int unsigned CLK_DIV = 4;
  localparam logic [31:0] DATA_A  = 32'h0;
  localparam logic [31:0] STAT_A  = 32'h4;
`ifdef PS2_TX_SLVERR_EN
  localparam logic SLVERR_EXP = 1'b1;
`else
  localparam logic SLVERR_EXP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic [2:0]  in_pprot = '0;
  logic        in_pwrite = 1'b0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = 4'hF;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        ps2_clk;
  logic        ps2_data;

  int checks = 0;
  int errors = 0;

  ps2_tx_apb #(.CLK_DIV(CLK_DIV), .FIFO_AW(3)) dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
    .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
    .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
    .in_pslverr(in_pslverr), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clock = ~clock;

  // Receiver model: samples ps2_data on each falling ps2_clk, 11 bits per frame.
  logic [10:0] rx_shift = '0;
  int          rx_bits = 0;
  int          fall_cnt = 0;
  time         start_t = 0;
  logic [10:0] rx_q [$];
  time         rx_t [$];

  always @(negedge ps2_clk or posedge reset) begin
    if (reset) begin
      rx_bits = 0;
    end else begin
      fall_cnt++;
      if (rx_bits == 0) start_t = $time;
      rx_shift[rx_bits] = ps2_data;
      rx_bits++;
      if (rx_bits == 11) begin
        rx_q.push_back(rx_shift);
        rx_t.push_back(start_t);
        rx_bits = 0;
      end
    end
  end

  // Data must never move while the clock line is held low.
  logic prev_clk = 1'b1;
  logic prev_data = 1'b1;
  int   viol = 0;
  always @(negedge clock) begin
    if (!reset && !prev_clk && !ps2_clk && (ps2_data !== prev_data)) viol++;
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    in_paddr = addr; in_pwdata = data; in_pwrite = 1'b1; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1 in_penable = 1'b1;
    #1 err = in_pslverr;
    @(posedge clock); #1 in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    in_paddr = addr; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1 in_penable = 1'b1;
    #1 data = in_prdata;
    @(posedge clock); #1 in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    bit done;
    s = '0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      apb_read(STAT_A, s);
      if (s[2] == 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle timeout status=%h", s);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic err;
    int bad;
    tick(3);
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      errors++; $display("FAIL reset_lines clk=%b data=%b want 1 1", ps2_clk, ps2_data);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_lines low_cycles=%0d want 0", bad); end
    checks++;
    if (in_prdata !== 32'h0 || in_pready !== 1'b0) begin
      errors++; $display("FAIL idle_bus prdata=%h pready=%b want 0 0", in_prdata, in_pready);
    end
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL reset_status got=%h want 00000001", rd); end
    apb_read(DATA_A, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL data_read got=%h want 0", rd); end
    apb_write(32'hC, 32'hFF, err);
    apb_read(32'h8, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reserved_read got=%h want 0", rd); end
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL reserved_write status=%h want 00000001", rd); end
  endtask

  task automatic test_frame();
    logic [31:0] rd;
    logic err;
    logic prev;
    int edges [$];
    rx_q.delete(); rx_t.delete();
    apb_write(DATA_A, 32'h1C, err);
    prev = ps2_clk;
    for (int k = 1; k <= 95; k++) begin
      tick(1);
      if (prev && !ps2_clk) edges.push_back(k);
      prev = ps2_clk;
    end
    checks++;
    if (edges.size() != 11) begin
      errors++; $display("FAIL frame_edges count=%0d want 11", edges.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (edges[i] != 5 + 8 * i) begin
          errors++; $display("FAIL edge_time bit=%0d got=%0d want=%0d", i, edges[i], 5 + 8 * i);
        end
      end
    end
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL busy_end_of_gap got=%h want 00000005", rd); end
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL busy_dropped got=%h want 00000001", rd); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 11'h438) begin
      errors++; $display("FAIL frame_1C frames=%0d first=%h want 1 438", rx_q.size(),
                         (rx_q.size() > 0) ? rx_q[0] : 11'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic err;
    int waited;
    wait_idle();
    rx_q.delete(); rx_t.delete();
    apb_write(DATA_A, 32'hF0, err);
    apb_write(DATA_A, 32'h1C, err);
    waited = 0;
    while (rx_q.size() < 2 && waited < 400) begin tick(1); waited++; end
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL loopback_frames got=%0d want 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 11'h7E0) begin errors++; $display("FAIL frame_F0 got=%h want 7E0", rx_q[0]); end
      checks++;
      if (rx_q[1] !== 11'h438) begin errors++; $display("FAIL frame_1C_2 got=%h want 438", rx_q[1]); end
      checks++;
      if (rx_t[1] - rx_t[0] != 970) begin
        errors++; $display("FAIL frame_period got=%0t want 970", rx_t[1] - rx_t[0]);
      end
    end
    wait_idle();
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL loopback_status got=%h want 00000001", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic err;
    wait_idle();
    rx_q.delete(); rx_t.delete();
    for (int i = 0; i < 9; i++) begin
      apb_write(DATA_A, 32'hA0 + 32'(i), err);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL fill_slverr idx=%0d got=%b want 0", i, err); end
    end
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h86) begin errors++; $display("FAIL full_status got=%h want 00000086", rd); end
    apb_write(DATA_A, 32'hEE, err);
    checks++;
    if (err !== SLVERR_EXP) begin errors++; $display("FAIL ovf_slverr got=%b want %b", err, SLVERR_EXP); end
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h8E) begin errors++; $display("FAIL ovf_status got=%h want 0000008E", rd); end
    apb_write(STAT_A, 32'h8, err);
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h86) begin errors++; $display("FAIL ovf_clear got=%h want 00000086", rd); end
    apb_write(STAT_A, 32'h1, err);
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL flush_full got=%h want 00000005", rd); end
    wait_idle();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 11'h740) begin
      errors++; $display("FAIL ovf_frames frames=%0d first=%h want 1 740", rx_q.size(),
                         (rx_q.size() > 0) ? rx_q[0] : 11'h0);
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    logic err;
    int f0;
    wait_idle();
    rx_q.delete(); rx_t.delete();
    f0 = fall_cnt;
    apb_write(DATA_A, 32'h11, err);
    apb_write(DATA_A, 32'h22, err);
    apb_write(DATA_A, 32'h33, err);
    tick(20);
    apb_write(STAT_A, 32'h1, err);
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL flush_status got=%h want 00000005", rd); end
    wait_idle();
    tick(150);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 11'h622) begin
      errors++; $display("FAIL flush_frames frames=%0d first=%h want 1 622", rx_q.size(),
                         (rx_q.size() > 0) ? rx_q[0] : 11'h0);
    end
    checks++;
    if (fall_cnt - f0 != 11) begin errors++; $display("FAIL flush_edges got=%0d want 11", fall_cnt - f0); end
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL flush_after got=%h want 00000001", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic err;
    int f0;
    wait_idle();
    apb_write(DATA_A, 32'h55, err);
    apb_write(DATA_A, 32'h66, err);
    rx_q.delete(); rx_t.delete();
    tick(45);
    checks++;
    if (ps2_clk !== 1'b0) begin errors++; $display("FAIL bit5_low clk=%b want 0", ps2_clk); end
    reset = 1'b1;
    #1;
    checks++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin
      errors++; $display("FAIL reset_abort clk=%b data=%b want 1 1", ps2_clk, ps2_data);
    end
    tick(2);
    reset = 1'b0;
    tick(1);
    f0 = fall_cnt;
    apb_read(STAT_A, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL reset_mid_status got=%h want 00000001", rd); end
    tick(200);
    checks++;
    if (fall_cnt != f0 || rx_q.size() != 0) begin
      errors++; $display("FAIL no_resume edges=%0d frames=%0d want 0 0", fall_cnt - f0, rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_reset_mid();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL data_stable_low got=%0d want 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/ps2_tx_apb.md
Name: ps2_tx_apb

Overview:
- APB-attached PS/2 device-side transmitter: the sending end of the PS/2 keyboard link.
- Software pushes scan-code bytes into an internal FIFO. The block serialises each byte into an 11-bit PS/2 frame and drives it on ps2_clk/ps2_data.
- Used as a keyboard emulator in SoC simulation and loopback; feeds the existing PS/2 keyboard receiver directly.

Parameters:
- CLK_DIV, 50: ps2_clk half-period in clock cycles; legal range ≥2.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_paddr  input  32  APB address; only [3:2] decoded
- in_psel  input  1  APB select
- in_penable  input  1  APB enable
- in_pprot  input  3  ignored
- in_pwrite  input  1  1=write
- in_pwdata  input  32  write data
- in_pstrb  input  4  ignored; full-word writes assumed by software
- in_pready  output  1  = in_psel & in_penable (zero wait states)
- in_prdata  output  32  read data
- in_pslverr  output  1  error response (see Optional Feature)
- ps2_clk  output  1  PS/2 clock, registered, idle 1
- ps2_data  output  1  PS/2 data, registered, idle 1

Behaviour:
- Reset: async, active-high. On assertion: FIFO empty, overflow=0, FSM=IDLE, ps2_clk=1, ps2_data=1. Reset mid-frame aborts the frame immediately; both lines return high.
- APB access fires on in_pready. in_prdata is driven only while in_pready & !in_pwrite, otherwise 0.
- paddr[3:2]=00 DATA:
  - Write pushes in_pwdata[7:0] if not full.
  - If full: byte dropped, overflow sticky set.
  - Read returns 0.
- paddr[3:2]=01 STATUS:
  - Read layout: bit0 empty, bit1 full, bit2 busy (FSM≠IDLE), bit3 overflow, bits[7:4] count (0..8), rest 0.
  - Write bit0=1 flushes the FIFO. Write bit3=1 clears overflow.
- paddr[3:2]=10/11: reads 0, writes ignored.
- Full is evaluated on the pre-pop count. A push to a full FIFO is rejected even if a pop occurs in the same cycle.
- Flush during a frame: the in-flight frame (already in the shift register) completes; queued bytes are discarded.
- If push and flush coincide, flush wins.
- Frame format, 11 bits: start 0, data[7:0] LSB first, odd parity (= ~^data), stop 1.
- FSM states: IDLE, SETUP, LOW, GAP. A single counter counts CLK_DIV; bit_idx runs 0..10.
  - IDLE: clk=1, data=1. When the FIFO is non-empty: pop into the shift register, set ps2_data=frame[0], bit_idx=0, go to SETUP.
  - SETUP: clk=1 for CLK_DIV cycles, data stable; then go to LOW.
  - LOW: clk=0 for CLK_DIV cycles; the receiver samples on the falling edge.
    - Then if bit_idx==10, go to GAP with data=1.
    - Otherwise bit_idx+1, data=next bit, go to SETUP.
  - GAP: clk=1, data=1 for 2*CLK_DIV cycles; then go to IDLE.
- ps2_data changes only in the cycle clk goes high, i.e. at the SETUP entry. It is never changed while clk is low.
- Frame period: 24*CLK_DIV+1 cycles from pop to the next possible pop. Back-to-back bytes stream without software intervention.

Optional Feature:
- Macro PS2_TX_SLVERR_EN.
- Defined: in_pslverr=1 during in_pready for a DATA write rejected because the FIFO is full; 0 otherwise. The overflow bit is still set.
- Undefined: in_pslverr tied 0. Overflow is reported only via STATUS bit3.

Test Plan:
- Reset, then read STATUS → 0x00000001 (empty). ps2_clk=ps2_data=1 held for 100 cycles.
- CLK_DIV=4, write 0x1C to DATA → 11 falling edges, sampled bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Busy drops 24*4 cycles after the pop.
- Loopback into the PS/2 keyboard receiver: write 0xF0 then 0x1C → receiver FIFO yields 0xF0 (parity 1) then 0x1C, no overflow.
- Write 9 bytes while the FSM is idle and CLK_DIV is large → first byte popped, 8 queued. 10th write rejected: overflow=1, pslverr=1 only with PS2_TX_SLVERR_EN. Write 0x8 to STATUS → overflow=0.
- Queue 3 bytes, flush mid-frame → current frame completes, STATUS count=0, no further frames.
- Assert reset during bit 5 of a frame → lines high immediately; FIFO empty after release; no partial frame resumes.
